// File: rtl/rgb_color_sequencer.sv
// rgb_color_sequencer
//   Upstream stage of the RGB PWM driver. Debounces a raw push-button and
//   cycles OFF -> WHITE -> BREATH -> RAINBOW -> OFF on each accepted press.
//   It produces three 9-bit duty values in 0..DUTY_MAX for the driver's
//   0..299 period counter. BREATH and RAINBOW advance one step per STEP_CYC
//   clock cycles.
//
//   Optional build macro STEP_SPEED_EN adds the speed_fast input. When
//   speed_fast is 1 the fade step is 4, otherwise it is 1. The input is
//   sampled on every step tick.
//
// Ports
//   clk        in   1  system clock (100 MHz)
//   rst        in   1  asynchronous, active-high reset
//   butt       in   1  raw, asynchronous, bouncing button (1 = pressed)
//   speed_fast in   1  fast fade select (STEP_SPEED_EN builds only)
//   R_time     out  9  red duty, 0..DUTY_MAX
//   G_time     out  9  green duty, 0..DUTY_MAX
//   B_time     out  9  blue duty, 0..DUTY_MAX
//   mode       out  2  0 OFF, 1 WHITE, 2 BREATH, 3 RAINBOW
module rgb_color_sequencer #(
  parameter int DEBOUNCE_CYC = 2000000,
  parameter int STEP_CYC     = 1000000,
  parameter int DUTY_MAX     = 300
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       butt,
`ifdef STEP_SPEED_EN
  input  logic       speed_fast,
`endif
  output logic [8:0] R_time,
  output logic [8:0] G_time,
  output logic [8:0] B_time,
  output logic [1:0] mode
);

  localparam int DBW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int PSW = (STEP_CYC > 1) ? $clog2(STEP_CYC) : 1;
  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYC - 1);
  localparam logic [PSW-1:0] PS_LAST = PSW'(STEP_CYC - 1);
  localparam logic [8:0]     DMAX    = 9'(DUTY_MAX);

  typedef enum logic [1:0] {
    M_OFF     = 2'd0,
    M_WHITE   = 2'd1,
    M_BREATH  = 2'd2,
    M_RAINBOW = 2'd3
  } mode_e;

  // Saturating step up. The sum is computed one bit wider than level so it
  // cannot wrap before the clamp.
  function automatic logic [8:0] sat_add(input logic [8:0] a, input logic [8:0] s);
    logic [9:0] sum;
    sum = {1'b0, a} + {1'b0, s};
    return (sum > {1'b0, DMAX}) ? DMAX : sum[8:0];
  endfunction

  // Saturating step down that floors at zero.
  function automatic logic [8:0] sat_sub(input logic [8:0] a, input logic [8:0] s);
    return (a < s) ? 9'd0 : (a - s);
  endfunction

  logic [1:0]     sync_q;
  logic           acc_q, acc_d;
  logic           press_q, press_d;
  logic [DBW-1:0] deb_q, deb_d;
  logic [PSW-1:0] presc_q, presc_d;
  mode_e          mode_q, mode_d;
  logic [8:0]     level_q, level_d;
  logic           dir_q, dir_d;      // 0 = up, 1 = down
  logic [1:0]     phase_q, phase_d;
  logic           tick;
  logic [8:0]     step;
  logic [8:0]     inv;

`ifdef STEP_SPEED_EN
  assign step = speed_fast ? 9'd4 : 9'd1;
`else
  assign step = 9'd1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= 2'b00;
      acc_q   <= 1'b0;
      press_q <= 1'b0;
      deb_q   <= '0;
      presc_q <= '0;
      mode_q  <= M_OFF;
      level_q <= 9'd0;
      dir_q   <= 1'b0;
      phase_q <= 2'd0;
    end else begin
      sync_q  <= {sync_q[0], butt};
      acc_q   <= acc_d;
      press_q <= press_d;
      deb_q   <= deb_d;
      presc_q <= presc_d;
      mode_q  <= mode_d;
      level_q <= level_d;
      dir_q   <= dir_d;
      phase_q <= phase_d;
    end
  end

  // Debounce: the accepted level only follows the synchronized button after
  // DEBOUNCE_CYC consecutive differing cycles. A press is the registered
  // 0->1 acceptance, so the mode register moves one edge later.
  always_comb begin
    deb_d   = '0;
    acc_d   = acc_q;
    press_d = 1'b0;
    if (sync_q[1] != acc_q) begin
      if (deb_q == DB_LAST) begin
        acc_d   = ~acc_q;
        press_d = ~acc_q;
      end else begin
        deb_d = deb_q + DBW'(1);
      end
    end
  end

  // Mode FSM and fade stepping. A press restarts the fade and the prescaler,
  // so a tick that lands on the same cycle is dropped.
  always_comb begin
    mode_d  = mode_q;
    level_d = level_q;
    dir_d   = dir_q;
    phase_d = phase_q;
    tick    = (presc_q == PS_LAST);
    presc_d = tick ? '0 : presc_q + PSW'(1);
    if (press_q) begin
      unique case (mode_q)
        M_OFF:     mode_d = M_WHITE;
        M_WHITE:   mode_d = M_BREATH;
        M_BREATH:  mode_d = M_RAINBOW;
        default:   mode_d = M_OFF;
      endcase
      level_d = 9'd0;
      dir_d   = 1'b0;
      phase_d = 2'd0;
      presc_d = '0;
    end else if (tick) begin
      unique case (mode_q)
        M_BREATH: begin
          if (!dir_q) begin
            if (level_q == DMAX) begin
              dir_d   = 1'b1;
              level_d = sat_sub(DMAX, step);
            end else begin
              level_d = sat_add(level_q, step);
            end
          end else begin
            if (level_q == 9'd0) begin
              dir_d   = 1'b0;
              level_d = sat_add(9'd0, step);
            end else begin
              level_d = sat_sub(level_q, step);
            end
          end
        end
        M_RAINBOW: begin
          if (level_q == DMAX) begin
            level_d = 9'd0;
            phase_d = (phase_q == 2'd2) ? 2'd0 : phase_q + 2'd1;
          end else begin
            level_d = sat_add(level_q, step);
          end
        end
        default: ;
      endcase
    end
  end

  // Output decode straight from the registered state. level never exceeds
  // DMAX, so the complement cannot underflow. The unreachable phase 3
  // decodes as phase 0.
  always_comb begin
    inv    = DMAX - level_q;
    R_time = 9'd0;
    G_time = 9'd0;
    B_time = 9'd0;
    unique case (mode_q)
      M_OFF: ;
      M_WHITE: begin
        R_time = DMAX;
        G_time = DMAX;
        B_time = DMAX;
      end
      M_BREATH: begin
        R_time = level_q;
        G_time = level_q;
        B_time = level_q;
      end
      default: begin
        unique case (phase_q)
          2'd1: begin
            G_time = inv;
            B_time = level_q;
          end
          2'd2: begin
            R_time = level_q;
            B_time = inv;
          end
          default: begin
            R_time = inv;
            G_time = level_q;
          end
        endcase
      end
    endcase
  end

  assign mode = mode_q;

endmodule

// File: tb/tb_rgb_color_sequencer.sv
module tb_rgb_color_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       butt = 1'b0;
`ifdef STEP_SPEED_EN
  logic       speed_fast = 1'b0;
`endif
  logic [8:0] R_time, G_time, B_time;
  logic [1:0] mode;

  rgb_color_sequencer #(
    .DEBOUNCE_CYC(4),
    .STEP_CYC    (2),
    .DUTY_MAX    (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .butt      (butt),
`ifdef STEP_SPEED_EN
    .speed_fast(speed_fast),
`endif
    .R_time    (R_time),
    .G_time    (G_time),
    .B_time    (B_time),
    .mode      (mode)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected output tuple. Absolute entries carry a cycle window. Relative
  // entries carry an exact cycle offset from the most recent mode change.
  typedef struct {
    int         id;
    logic [1:0] m;
    logic [8:0] r;
    logic [8:0] g;
    logic [8:0] b;
    int         lo;
    int         hi;
    bit         rel;
  } exp_t;

  exp_t q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   n_pop  = 0;
  int   next_id = 0;

  task automatic push_abs(input int m, input int r, input int g, input int b,
                          input int lo, input int hi);
    exp_t e;
    e.id = next_id; e.m = 2'(m); e.r = 9'(r); e.g = 9'(g); e.b = 9'(b);
    e.lo = lo; e.hi = hi; e.rel = 1'b0;
    next_id++;
    q.push_back(e);
  endtask

  task automatic push_rel(input int m, input int r, input int g, input int b,
                          input int off);
    exp_t e;
    e.id = next_id; e.m = 2'(m); e.r = 9'(r); e.g = 9'(g); e.b = 9'(b);
    e.lo = off; e.hi = off; e.rel = 1'b1;
    next_id++;
    q.push_back(e);
  endtask

  // Monitor: every visible change of {mode,R,G,B} is one DUT output event.
  // On a mode change, unconsumed ramp entries of the old mode are dropped.
  initial begin : monitor
    logic [1:0] last_m;
    logic [8:0] last_r, last_g, last_b;
    int         mchg;
    int         lo, hi;
    exp_t       e;
    last_m = 2'd0; last_r = 9'h1ff; last_g = 9'd0; last_b = 9'd0;
    mchg = 0;
    forever begin
      @(negedge clk);
      if ({mode, R_time, G_time, B_time} != {last_m, last_r, last_g, last_b}) begin
        if (mode != last_m) begin
          mchg = cyc;
          while (q.size() > 0 && q[0].rel) e = q.pop_front();
        end
        n_cmp++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_change cyc=%0d got mode=%0d RGB=%0d,%0d,%0d required no change",
                   cyc, mode, R_time, G_time, B_time);
        end else begin
          e = q.pop_front();
          n_pop++;
          lo = e.rel ? mchg + e.lo : e.lo;
          hi = e.rel ? mchg + e.hi : e.hi;
          if (mode !== e.m || R_time !== e.r || G_time !== e.g || B_time !== e.b ||
              cyc < lo || cyc > hi) begin
            n_fail++;
            $display("FAIL out_check id=%0d got mode=%0d RGB=%0d,%0d,%0d at cyc %0d required mode=%0d RGB=%0d,%0d,%0d in cyc %0d..%0d",
                     e.id, mode, R_time, G_time, B_time, cyc, e.m, e.r, e.g, e.b, lo, hi);
          end
        end
        last_m = mode; last_r = R_time; last_g = G_time; last_b = B_time;
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_drained(input string nm);
    n_cmp++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL %s pending_outputs got %0d required 0", nm, q.size());
    end
  endtask

  task automatic chk_progress(input string nm, input int got, input int need);
    n_cmp++;
    if (got < need) begin
      n_fail++;
      $display("FAIL %s outputs_seen got %0d required >= %0d", nm, got, need);
    end
  endtask

  task automatic wait_pops(input string nm, input int target, input int budget);
    for (int i = 0; i < budget && n_pop < target; i++) @(posedge clk);
    #1;
    chk_progress(nm, n_pop, target);
  endtask

  // Triangle 0,1,..,8,7,..,0,1,.. for the unit-step breath ramp.
  function automatic int breath_lvl(input int k);
    int m;
    m = k % 16;
    return (m <= 8) ? m : 16 - m;
  endfunction

  initial begin : stim
    int t0, base;
    int ph, l, r, g, b, pr, pg, pb;

    // Reset state while rst is held
    push_abs(0, 0, 0, 0, 0, 3);
    cycles(3);
    rst = 1'b0;
    cycles(5);

    // Bounce rejection, then one press from a stable high level
    for (int i = 0; i < 10; i++) begin
      butt = (i % 2 == 0);
      cycles(2);
    end
    t0 = cyc;
    butt = 1'b1;
    push_abs(1, 8, 8, 8, t0 + 6, t0 + 8);
    cycles(10);
    butt = 1'b0;
    cycles(20);
    chk_drained("bounce_press");

    // Long hold in WHITE: one advance to BREATH, then the unit ramp runs
    t0 = cyc;
    butt = 1'b1;
    push_abs(2, 0, 0, 0, t0 + 6, t0 + 8);
    base = n_pop;
    for (int k = 1; k <= 70; k++)
      push_rel(2, breath_lvl(k), breath_lvl(k), breath_lvl(k), 2 * k);
    cycles(100);
    butt = 1'b0;
    cycles(20);
    chk_progress("breath_ramp", n_pop - base, 50);

    // RAINBOW: only visible tuple changes are queued
    t0 = cyc;
    butt = 1'b1;
    push_abs(3, 8, 0, 0, t0 + 6, t0 + 8);
    base = n_pop;
    pr = 8; pg = 0; pb = 0;
    for (int k = 1; k <= 45; k++) begin
      ph = (k / 9) % 3;
      l  = k % 9;
      if (ph == 0) begin r = 8 - l; g = l;     b = 0;     end
      else if (ph == 1) begin r = 0; g = 8 - l; b = l;     end
      else begin              r = l; g = 0;     b = 8 - l; end
      if (r != pr || g != pg || b != pb) push_rel(3, r, g, b, 2 * k);
      pr = r; pg = g; pb = b;
    end
    cycles(12);
    butt = 1'b0;
    cycles(68);
    chk_progress("rainbow_ramp", n_pop - base, 25);

    // Asynchronous reset mid-RAINBOW, between clock edges
    #2;
    push_abs(0, 0, 0, 0, cyc, cyc);
    rst = 1'b1;
    cycles(3);
    rst = 1'b0;
    cycles(20);
    chk_drained("reset_idle");

    // Sequencer works again after reset
    t0 = cyc;
    butt = 1'b1;
    push_abs(1, 8, 8, 8, t0 + 6, t0 + 8);
    cycles(12);
    butt = 1'b0;
    cycles(15);
    chk_drained("post_reset_press");

`ifdef STEP_SPEED_EN
    // Fast breath: 0,4,8,4,0,4,... endpoints hit exactly
    speed_fast = 1'b1;
    t0 = cyc;
    butt = 1'b1;
    push_abs(2, 0, 0, 0, t0 + 6, t0 + 8);
    base = n_pop;
    for (int k = 1; k <= 12; k++) begin
      l = (k % 4 == 2) ? 8 : ((k % 2 == 1) ? 4 : 0);
      push_rel(2, l, l, l, 2 * k);
    end
    cycles(12);
    butt = 1'b0;
    wait_pops("fast_breath", base + 9, 60);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog got timeout required finish");
    $fatal(1, "watchdog");
  end

endmodule
